// File: rtl/vx_irq_ctx_ctrl.sv
// Per-core IRQ controller: stalls one warp, saves its PC/tmask/GPRs, redirects it to an ISR vector, then restores it.
// Latency: 2 cycles from request to first context read on a drained warp; all handshakes hold valid+payload until ready.
module vx_irq_ctx_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int XLEN         = 32,
    parameter int NUM_SRC      = 4,
    parameter int NUM_CTX_REGS = 31,
    parameter int VEC_STRIDE   = 64,
    parameter int TIMEOUT      = 255,
    parameter int ALLOW_W0     = 0,
    localparam int WID_W       = $clog2(NUM_WARPS),
    localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SRC-1:0]     i_irq_req,
    input  logic [NUM_SRC-1:0]     i_irq_mask,
    input  logic [XLEN-1:0]        i_isr_base,
    input  logic [NUM_WARPS-1:0]   i_warp_active,
    input  logic [NUM_WARPS-1:0]   i_warp_drained,
    input  logic [XLEN-1:0]        i_warp_pc,
    input  logic [NUM_THREADS-1:0] i_warp_tmask,
    output logic                   o_stall_valid,
    output logic [WID_W-1:0]       o_stall_wid,
    output logic                   o_redir_valid,
    input  logic                   i_redir_ready,
    output logic [XLEN-1:0]        o_redir_pc,
    output logic [NUM_THREADS-1:0] o_redir_tmask,
    output logic                   o_ctx_rd_valid,
    input  logic                   i_ctx_rd_ready,
    output logic [4:0]             o_ctx_rd_addr,
    input  logic [XLEN-1:0]        i_ctx_rd_data,
    output logic                   o_ctx_wr_valid,
    input  logic                   i_ctx_wr_ready,
    output logic [4:0]             o_ctx_wr_addr,
    output logic [XLEN-1:0]        o_ctx_wr_data,
    input  logic                   i_isr_done,
    output logic [NUM_SRC-1:0]     o_irq_ack,
    output logic                   o_irq_timeout,
    output logic                   o_busy
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PC_SWAP, S_WAIT_ISR, S_REVERT
    } state_t;

    typedef enum logic [1:0] {
        PH_DRAIN, PH_MOVE, PH_REDIR
    } phase_t;

    state_t                 r_state, w_state_nxt;
    phase_t                 r_phase;
    logic [SRC_W-1:0]       r_src, w_src;
    logic [WID_W-1:0]       r_wid, w_tgt;
    logic                   w_tgt_vld;
    logic [NUM_SRC-1:0]     w_pending;
    logic [CNT_W-1:0]       r_cnt;
    logic [4:0]             r_idx;
    logic [XLEN-1:0]        r_pc, r_redir_pc;
    logic [NUM_THREADS-1:0] r_tmask, r_redir_tmask;
    logic [NUM_SRC-1:0]     r_irq_ack;
    logic                   r_irq_timeout;
    logic [XLEN-1:0]        r_ctx [NUM_CTX_REGS];
    logic                   w_rd_fire, w_wr_fire, w_redir_fire, w_drained, w_last, w_cnt_end;

    assign w_pending = i_irq_req & i_irq_mask;

    always_comb begin
        w_src = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (w_pending[s]) w_src = SRC_W'(s);
        end
    end

    // Warp 0 is only a fallback so the core never loses its last running warp by default.
    always_comb begin
        w_tgt     = '0;
        w_tgt_vld = 1'b0;
        for (int w = NUM_WARPS - 1; w >= 1; w--) begin
            if (i_warp_active[w]) begin
                w_tgt     = WID_W'(w);
                w_tgt_vld = 1'b1;
            end
        end
        if (!w_tgt_vld && (ALLOW_W0 != 0) && i_warp_active[0]) begin
            w_tgt     = '0;
            w_tgt_vld = 1'b1;
        end
    end

    assign w_drained = i_warp_drained[r_wid];
    assign w_last    = (r_idx == 5'(NUM_CTX_REGS));
    assign w_cnt_end = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign o_stall_valid  = (r_state == S_WAIT) || (r_state == S_PC_SWAP) || (r_state == S_REVERT);
    assign o_stall_wid    = r_wid;
    assign o_busy         = (r_state != S_IDLE);
    assign o_ctx_rd_valid = (r_state == S_PC_SWAP) && (r_phase == PH_MOVE);
    assign o_ctx_rd_addr  = r_idx;
    assign o_ctx_wr_valid = (r_state == S_REVERT) && (r_phase == PH_MOVE);
    assign o_ctx_wr_addr  = r_idx;
    assign o_ctx_wr_data  = o_ctx_wr_valid ? r_ctx[r_idx - 5'd1] : '0;
    assign o_redir_valid  = ((r_state == S_PC_SWAP) || (r_state == S_REVERT)) && (r_phase == PH_REDIR);
    assign o_redir_pc     = r_redir_pc;
    assign o_redir_tmask  = r_redir_tmask;
    assign o_irq_ack      = r_irq_ack;
    assign o_irq_timeout  = r_irq_timeout;

    assign w_rd_fire    = o_ctx_rd_valid & i_ctx_rd_ready;
    assign w_wr_fire    = o_ctx_wr_valid & i_ctx_wr_ready;
    assign w_redir_fire = o_redir_valid & i_redir_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if ((w_pending != '0) && w_tgt_vld) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_drained)      w_state_nxt = S_PC_SWAP;
                else if (w_cnt_end) w_state_nxt = S_IDLE;
            end
            S_PC_SWAP:  if (w_redir_fire) w_state_nxt = S_WAIT_ISR;
            S_WAIT_ISR: if (i_isr_done)   w_state_nxt = S_REVERT;
            S_REVERT:   if (w_redir_fire) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_phase       <= PH_DRAIN;
            r_src         <= '0;
            r_wid         <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pc          <= '0;
            r_tmask       <= '0;
            r_redir_pc    <= '0;
            r_redir_tmask <= '0;
            r_irq_ack     <= '0;
            r_irq_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_irq_ack     <= '0;
            r_irq_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_WAIT) begin
                        r_src <= w_src;
                        r_wid <= w_tgt;
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_drained) begin
                        r_pc    <= i_warp_pc;
                        r_tmask <= i_warp_tmask;
                        r_idx   <= 5'd1;
                        r_phase <= PH_MOVE;
                    end else if (w_cnt_end) begin
                        r_irq_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PC_SWAP: begin
                    if (w_rd_fire) begin
                        if (w_last) begin
                            r_phase       <= PH_REDIR;
                            r_redir_pc    <= i_isr_base + XLEN'(r_src) * XLEN'(VEC_STRIDE);
                            r_redir_tmask <= NUM_THREADS'(1);
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                    if (w_redir_fire) r_irq_ack <= NUM_SRC'(1) << r_src;
                end
                S_WAIT_ISR: begin
                    if (i_isr_done) r_phase <= PH_DRAIN;
                end
                S_REVERT: begin
                    if (r_phase == PH_DRAIN && w_drained) begin
                        r_phase <= PH_MOVE;
                        r_idx   <= 5'd1;
                    end else if (w_wr_fire) begin
                        if (w_last) begin
                            r_phase       <= PH_REDIR;
                            r_redir_pc    <= r_pc;
                            r_redir_tmask <= r_tmask;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saved context is don't-care after reset, so the buffer carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_rd_fire) r_ctx[r_idx - 5'd1] <= i_ctx_rd_data;
    end

endmodule

// File: tb/tb_vx_irq_ctx_ctrl.sv
// Directed bench for vx_irq_ctx_ctrl: vector table of full preemptions plus timeout and reset corner sequences.
module tb_vx_irq_ctx_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_req, irq_mask, warp_active, warp_drained, warp_tmask;
    logic [31:0] isr_base, warp_pc, ctx_rd_data;
    logic        redir_ready, ctx_rd_ready, ctx_wr_ready, isr_done;
    logic        sel_b;

    logic        a_stall_valid, b_stall_valid, a_redir_valid, b_redir_valid;
    logic [1:0]  a_stall_wid, b_stall_wid;
    logic [31:0] a_redir_pc, b_redir_pc, a_ctx_wr_data, b_ctx_wr_data;
    logic [3:0]  a_redir_tmask, b_redir_tmask, a_irq_ack, b_irq_ack;
    logic        a_ctx_rd_valid, b_ctx_rd_valid, a_ctx_wr_valid, b_ctx_wr_valid;
    logic [4:0]  a_ctx_rd_addr, b_ctx_rd_addr, a_ctx_wr_addr, b_ctx_wr_addr;
    logic        a_irq_timeout, b_irq_timeout, a_busy, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vx_irq_ctx_ctrl #(.TIMEOUT(8), .ALLOW_W0(0)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_irq_req(irq_req), .i_irq_mask(irq_mask),
        .i_isr_base(isr_base), .i_warp_active(warp_active), .i_warp_drained(warp_drained),
        .i_warp_pc(warp_pc), .i_warp_tmask(warp_tmask),
        .o_stall_valid(a_stall_valid), .o_stall_wid(a_stall_wid),
        .o_redir_valid(a_redir_valid), .i_redir_ready(redir_ready),
        .o_redir_pc(a_redir_pc), .o_redir_tmask(a_redir_tmask),
        .o_ctx_rd_valid(a_ctx_rd_valid), .i_ctx_rd_ready(ctx_rd_ready),
        .o_ctx_rd_addr(a_ctx_rd_addr), .i_ctx_rd_data(ctx_rd_data),
        .o_ctx_wr_valid(a_ctx_wr_valid), .i_ctx_wr_ready(ctx_wr_ready),
        .o_ctx_wr_addr(a_ctx_wr_addr), .o_ctx_wr_data(a_ctx_wr_data),
        .i_isr_done(isr_done), .o_irq_ack(a_irq_ack), .o_irq_timeout(a_irq_timeout),
        .o_busy(a_busy)
    );

    vx_irq_ctx_ctrl #(.TIMEOUT(8), .ALLOW_W0(1)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_irq_req(irq_req), .i_irq_mask(irq_mask),
        .i_isr_base(isr_base), .i_warp_active(warp_active), .i_warp_drained(warp_drained),
        .i_warp_pc(warp_pc), .i_warp_tmask(warp_tmask),
        .o_stall_valid(b_stall_valid), .o_stall_wid(b_stall_wid),
        .o_redir_valid(b_redir_valid), .i_redir_ready(redir_ready),
        .o_redir_pc(b_redir_pc), .o_redir_tmask(b_redir_tmask),
        .o_ctx_rd_valid(b_ctx_rd_valid), .i_ctx_rd_ready(ctx_rd_ready),
        .o_ctx_rd_addr(b_ctx_rd_addr), .i_ctx_rd_data(ctx_rd_data),
        .o_ctx_wr_valid(b_ctx_wr_valid), .i_ctx_wr_ready(ctx_wr_ready),
        .o_ctx_wr_addr(b_ctx_wr_addr), .o_ctx_wr_data(b_ctx_wr_data),
        .i_isr_done(isr_done), .o_irq_ack(b_irq_ack), .o_irq_timeout(b_irq_timeout),
        .o_busy(b_busy)
    );

    wire        m_stall_valid  = sel_b ? b_stall_valid  : a_stall_valid;
    wire [1:0]  m_stall_wid    = sel_b ? b_stall_wid    : a_stall_wid;
    wire        m_redir_valid  = sel_b ? b_redir_valid  : a_redir_valid;
    wire [31:0] m_redir_pc     = sel_b ? b_redir_pc     : a_redir_pc;
    wire [3:0]  m_redir_tmask  = sel_b ? b_redir_tmask  : a_redir_tmask;
    wire        m_ctx_rd_valid = sel_b ? b_ctx_rd_valid : a_ctx_rd_valid;
    wire [4:0]  m_ctx_rd_addr  = sel_b ? b_ctx_rd_addr  : a_ctx_rd_addr;
    wire        m_ctx_wr_valid = sel_b ? b_ctx_wr_valid : a_ctx_wr_valid;
    wire [4:0]  m_ctx_wr_addr  = sel_b ? b_ctx_wr_addr  : a_ctx_wr_addr;
    wire [31:0] m_ctx_wr_data  = sel_b ? b_ctx_wr_data  : a_ctx_wr_data;
    wire [3:0]  m_irq_ack      = sel_b ? b_irq_ack      : a_irq_ack;
    wire        m_irq_timeout  = sel_b ? b_irq_timeout  : a_irq_timeout;
    wire        m_busy         = sel_b ? b_busy         : a_busy;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  mask;
        logic [3:0]  active;
        logic [31:0] base;
        bit          rnd;
        bit          use_b;
        bit          exp_act;
        logic [1:0]  exp_wid;
        logic [31:0] exp_pc;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ready(input bit rnd);
        ctx_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ctx_wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        redir_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ctx_rd_data  = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq_req = '0; irq_mask = '0; isr_done = 1'b0;
        warp_drained = '1;
        ctx_rd_ready = 1'b1; ctx_wr_ready = 1'b1; redir_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},   {63'd0, m_stall_valid}, 64'd0);
        chk({tag, "_rd_vld"},  {63'd0, m_ctx_rd_valid}, 64'd0);
        chk({tag, "_wr_vld"},  {63'd0, m_ctx_wr_valid}, 64'd0);
        chk({tag, "_redir"},   {63'd0, m_redir_valid}, 64'd0);
        chk({tag, "_ack"},     {60'd0, m_irq_ack}, 64'd0);
        chk({tag, "_timeout"}, {63'd0, m_irq_timeout}, 64'd0);
        chk({tag, "_busy"},    {63'd0, m_busy}, 64'd0);
        chk({tag, "_rd_addr"}, {59'd0, m_ctx_rd_addr}, 64'd0);
        chk({tag, "_pc"},      {32'd0, m_redir_pc}, 64'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] saved [31];
        int          lat, nrd, nwr, guard;
        bit          hold;
        logic [4:0]  hold_addr;
        v = vecs[i];
        do_reset();
        sel_b = v.use_b;
        irq_req = v.req; irq_mask = v.mask; warp_active = v.active; isr_base = v.base;
        warp_pc = 32'h4000_0000 + 32'(i) * 32'h104;
        warp_tmask = 4'(i * 3 + 5);
        drive_ready(v.rnd);
        if (!v.exp_act) begin
            repeat (3) @(negedge clk);
            isr_done = 1'b1;
            @(negedge clk);
            isr_done = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_busy", i), {63'd0, m_busy}, 64'd0);
            chk($sformatf("v%0d_idle_stall", i), {63'd0, m_stall_valid}, 64'd0);
            return;
        end
        lat = 0;
        while (!m_ctx_rd_valid && lat < 10) begin
            @(negedge clk); lat++; drive_ready(v.rnd);
        end
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
        chk($sformatf("v%0d_stall_wid", i), {62'd0, m_stall_wid}, {62'd0, v.exp_wid});
        chk($sformatf("v%0d_stall_vld", i), {63'd0, m_stall_valid}, 64'd1);

        nrd = 0; guard = 0; hold = 1'b0; hold_addr = '0;
        while (nrd < 31 && guard < 500) begin
            if (hold)
                chk($sformatf("v%0d_rd_hold", i), {58'd0, m_ctx_rd_valid, m_ctx_rd_addr}, {58'd0, 1'b1, hold_addr});
            hold = m_ctx_rd_valid && !ctx_rd_ready;
            hold_addr = m_ctx_rd_addr;
            if (m_ctx_rd_valid && ctx_rd_ready) begin
                chk($sformatf("v%0d_rd_addr[%0d]", i, nrd), {59'd0, m_ctx_rd_addr}, 64'(nrd + 1));
                saved[nrd] = ctx_rd_data;
                nrd++;
            end
            @(negedge clk); guard++; drive_ready(v.rnd);
        end
        chk($sformatf("v%0d_nreads", i), 64'(nrd), 64'd31);

        guard = 0;
        while (!(m_redir_valid && redir_ready) && guard < 100) begin
            @(negedge clk); guard++; drive_ready(v.rnd);
        end
        chk($sformatf("v%0d_isr_redir_seen", i), {63'd0, m_redir_valid}, 64'd1);
        chk($sformatf("v%0d_isr_pc", i), {32'd0, m_redir_pc}, {32'd0, v.exp_pc});
        chk($sformatf("v%0d_isr_tmask", i), {60'd0, m_redir_tmask}, 64'd1);
        chk($sformatf("v%0d_ack_early", i), {60'd0, m_irq_ack}, 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d_ack", i), {60'd0, m_irq_ack}, {60'd0, v.exp_ack});
        chk($sformatf("v%0d_isr_stall", i), {63'd0, m_stall_valid}, 64'd0);
        chk($sformatf("v%0d_isr_busy", i), {63'd0, m_busy}, 64'd1);
        irq_req = '0;
        warp_drained = '0;
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", i), {60'd0, m_irq_ack}, 64'd0);
        isr_done = 1'b1;
        @(negedge clk);
        isr_done = 1'b0;
        repeat (12) @(negedge clk);
        chk($sformatf("v%0d_rev_stall", i), {63'd0, m_stall_valid}, 64'd1);
        chk($sformatf("v%0d_rev_nowr", i), {63'd0, m_ctx_wr_valid}, 64'd0);
        chk($sformatf("v%0d_rev_noto", i), {63'd0, m_irq_timeout}, 64'd0);
        warp_drained = '1;
        drive_ready(v.rnd);

        nwr = 0; guard = 0;
        while (nwr < 31 && guard < 500) begin
            if (m_ctx_wr_valid && ctx_wr_ready) begin
                chk($sformatf("v%0d_wr_addr[%0d]", i, nwr), {59'd0, m_ctx_wr_addr}, 64'(nwr + 1));
                chk($sformatf("v%0d_wr_data[%0d]", i, nwr), {32'd0, m_ctx_wr_data}, {32'd0, saved[nwr]});
                nwr++;
            end
            @(negedge clk); guard++; drive_ready(v.rnd);
        end
        chk($sformatf("v%0d_nwrites", i), 64'(nwr), 64'd31);

        guard = 0;
        while (!(m_redir_valid && redir_ready) && guard < 100) begin
            @(negedge clk); guard++; drive_ready(v.rnd);
        end
        chk($sformatf("v%0d_ret_pc", i), {32'd0, m_redir_pc}, {32'd0, warp_pc});
        chk($sformatf("v%0d_ret_tmask", i), {60'd0, m_redir_tmask}, {60'd0, warp_tmask});
        @(negedge clk);
        chk($sformatf("v%0d_end_busy", i), {63'd0, m_busy}, 64'd0);
        chk($sformatf("v%0d_end_stall", i), {63'd0, m_stall_valid}, 64'd0);
    endtask

    initial begin
        //           req      mask     active   base           rnd b  act wid  exp_pc         ack
        vecs[0] = '{4'b0100, 4'b1111, 4'b0110, 32'h0000_8000, 0, 0, 1, 2'd1, 32'h0000_8080, 4'b0100};
        vecs[1] = '{4'b0011, 4'b0010, 4'b0110, 32'h0000_8000, 1, 0, 1, 2'd1, 32'h0000_8040, 4'b0010};
        vecs[2] = '{4'b1000, 4'b1111, 4'b1000, 32'h0000_1000, 1, 0, 1, 2'd3, 32'h0000_10C0, 4'b1000};
        vecs[3] = '{4'b0001, 4'b1111, 4'b1111, 32'hFFFF_FFC0, 0, 0, 1, 2'd1, 32'hFFFF_FFC0, 4'b0001};
        vecs[4] = '{4'b0111, 4'b0100, 4'b0100, 32'h0000_2000, 1, 0, 1, 2'd2, 32'h0000_2080, 4'b0100};
        vecs[5] = '{4'b1000, 4'b1111, 4'b0110, 32'hFFFF_FFC0, 1, 0, 1, 2'd1, 32'h0000_0080, 4'b1000};
        vecs[6] = '{4'b0001, 4'b1110, 4'b0110, 32'h0000_3000, 0, 0, 0, 2'd0, 32'h0,         4'b0000};
        vecs[7] = '{4'b0001, 4'b1111, 4'b0001, 32'h0000_3000, 0, 0, 0, 2'd0, 32'h0,         4'b0000};
        vecs[8] = '{4'b0001, 4'b1111, 4'b0001, 32'h0000_3000, 0, 1, 1, 2'd0, 32'h0000_3000, 4'b0001};

        sel_b = 1'b0;
        warp_active = '0; isr_base = '0; warp_pc = '0; warp_tmask = '0; ctx_rd_data = '0;
        do_reset();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        for (int i = 0; i < 9; i++) run_vec(i);

        // Drain timeout: 8 WAIT cycles, then a pulse in IDLE, then immediate re-entry.
        do_reset();
        sel_b = 1'b0;
        warp_drained = '0; warp_active = 4'b0110; irq_req = 4'b0001; irq_mask = 4'b1111;
        isr_base = 32'h0000_8000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("to_wait_stall[%0d]", c), {63'd0, m_stall_valid}, 64'd1);
            chk($sformatf("to_wait_nopulse[%0d]", c), {63'd0, m_irq_timeout}, 64'd0);
        end
        @(negedge clk);
        chk("to_pulse", {63'd0, m_irq_timeout}, 64'd1);
        chk("to_stall_drop", {63'd0, m_stall_valid}, 64'd0);
        chk("to_idle", {63'd0, m_busy}, 64'd0);
        chk("to_no_ack", {60'd0, m_irq_ack}, 64'd0);
        @(negedge clk);
        chk("to_reenter", {63'd0, m_busy}, 64'd1);
        chk("to_pulse_one", {63'd0, m_irq_timeout}, 64'd0);

        // Reset in the middle of the context save.
        do_reset();
        sel_b = 1'b0;
        warp_active = 4'b0110; irq_req = 4'b0010; irq_mask = 4'b1111; isr_base = 32'h0000_8000;
        drive_ready(1'b1);
        begin
            int nrd = 0;
            int guard = 0;
            while (nrd < 5 && guard < 200) begin
                if (m_ctx_rd_valid && ctx_rd_ready) nrd++;
                @(negedge clk); guard++; drive_ready(1'b1);
            end
            chk("rst_mid_reads", 64'(nrd), 64'd5);
        end
        chk("rst_mid_in_swap", {63'd0, m_ctx_rd_valid | m_redir_valid}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        redir_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_ack", {60'd0, m_irq_ack}, 64'd0);
        irq_req = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_after", {63'd0, m_busy}, 64'd0);
        chk("rst_mid_after_ack", {60'd0, m_irq_ack}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_irq_ctx_ctrl.md
Name: vx_irq_ctx_ctrl

Overview:
Multi-source, per-core hardware interrupt controller that preempts one SIMT warp, saves its PC, thread mask and register context, redirects it to a per-source ISR vector, then restores the context and resumes it when the ISR signals completion. It generalises the five-state IRQ flow (IDLE/WAIT/PC_SWAP/WAIT_ISR/REVERT_WARP) to parametrised source count, warp count and context depth. It adds a drain timeout and source masking. It sits beside the warp scheduler and drives the scheduler's stall and redirect ports and a register-file context port.

Parameters:
NUM_WARPS, 4, warps per core (>=2)
NUM_THREADS, 4, lanes per warp
XLEN, 32, data/PC width
NUM_SRC, 4, interrupt sources (>=1)
NUM_CTX_REGS, 31, GPRs moved per context (x1..x31)
VEC_STRIDE, 64, bytes between ISR vectors
TIMEOUT, 255, max drain-wait cycles (>=1)
ALLOW_W0, 0, 1 = warp 0 may be preempted when it is the only active warp

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
irq_req  in  NUM_SRC  level-sensitive pending requests
irq_mask  in  NUM_SRC  1 = source enabled
isr_base  in  XLEN  vector table base
warp_active  in  NUM_WARPS  active warps from scheduler
warp_drained  in  NUM_WARPS  warp has no in-flight instructions
warp_pc  in  XLEN  PC of stall_wid, valid while warp_drained[stall_wid]
warp_tmask  in  NUM_THREADS  tmask of stall_wid, same validity
stall_valid  out  1  hold stall_wid out of scheduling
stall_wid  out  log2(NUM_WARPS)  target warp
redir_valid/redir_ready  out/in  1  redirect handshake
redir_pc  out  XLEN  new PC
redir_tmask  out  NUM_THREADS  new thread mask
ctx_rd_valid/ctx_rd_ready  out/in  1  context read request
ctx_rd_addr  out  5  GPR index (1..NUM_CTX_REGS)
ctx_rd_data  in  XLEN  read data, valid on rd fire
ctx_wr_valid/ctx_wr_ready  out/in  1  context write request
ctx_wr_addr  out  5  GPR index
ctx_wr_data  out  XLEN  write data
isr_done  in  1  single-cycle ISR-return pulse
irq_ack  out  NUM_SRC  one-hot ack pulse
irq_timeout  out  1  one-cycle drain-timeout pulse
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; all outputs 0; counters 0. Context buffer contents are don't-care. Reset mid-operation abandons the preemption and releases the stall the next cycle.
- pending = irq_req & irq_mask. Selected source = lowest set index.
- Target warp = lowest active index in 1..NUM_WARPS-1. If there is none and ALLOW_W0=1 with warp_active[0]=1, the target is warp 0. Otherwise there is no target.
- IDLE: if pending!=0 and a target exists, latch src and wid, go to WAIT. stall_valid=1 from the next cycle.
- WAIT: count cycles. If warp_drained[wid]=1, latch warp_pc and warp_tmask and go to PC_SWAP. If count reaches TIMEOUT first, pulse irq_timeout, drop the stall and return to IDLE; the source stays pending.
- PC_SWAP: issue reads for addr 1..NUM_CTX_REGS in order, one per ctx_rd fire, storing each result into the buffer. Then assert redir_valid with redir_pc = isr_base + src*VEC_STRIDE (XLEN-truncated) and redir_tmask = lane0 only (1). On redir fire: pulse irq_ack[src] and go to WAIT_ISR.
- WAIT_ISR: the stall is released so the warp runs the ISR. New pending requests are ignored. On isr_done, go to REVERT_WARP.
- REVERT_WARP: reassert the stall. Wait for warp_drained[wid]; this wait has no timeout. Write the buffer back to addr 1..NUM_CTX_REGS, one per ctx_wr fire. Then redirect to the saved pc and tmask. On redir fire, go to IDLE; the stall drops the next cycle.
- Handshake rules:
  - Once asserted, valid and payload hold until ready.
  - Back-to-back fires are allowed.
  - Minimum context move is NUM_CTX_REGS cycles each way.
- isr_done outside WAIT_ISR is ignored. irq_ack and irq_timeout are never simultaneous.
- Change of irq_req/irq_mask after latching has no effect on the current preemption.
- Latency IDLE->first ctx_rd_valid: 2 cycles if the warp is already drained.

Test Plan:
- Defaults, warp_active=4'b0110, drained, irq_req=4'b0100, isbase=0x8000, always-ready:
  - stall_wid=1
  - 31 reads addr 1..31
  - redir_pc=0x8080, tmask=0001
  - irq_ack=0100
- Continuing, isr_done pulse:
  - 31 writes return the read data in order
  - redir_pc and tmask equal the saved values
  - busy drops
- irq_req=4'b0011 with irq_mask=4'b0010 -> source 1 chosen, redir_pc=isr_base+64.
- warp_drained held 0, TIMEOUT=8 -> irq_timeout pulse after 8 WAIT cycles, stall released, state IDLE, re-entry next cycle.
- Only warp 0 active:
  - ALLOW_W0=0 -> no action.
  - ALLOW_W0=1 -> stall_wid=0.
- Random ctx_rd_ready/ctx_wr_ready/redir_ready stalls; reset asserted during PC_SWAP -> all outputs 0 next cycle, no irq_ack.
